// File: rtl/gci_std_kmc_ps2_scancode_decoder.sv
// PS/2 Set-2 scancode decoder: turns received byte strobes into key events
// (extended / break / code) and queues them in a show-ahead event FIFO.
module gci_std_kmc_ps2_scancode_decoder #(
  parameter int P_FIFO_DEPTH   = 16,
  parameter int P_FIFO_DEPTH_N = 4,
  parameter int P_TIMEOUT      = 250000,
  parameter int P_TIMEOUT_W    = 18
) (
  input  logic                      iCLOCK,
  input  logic                      iRESET_SYNC,
  input  logic                      iPS2_REQ,
  input  logic [7:0]                iPS2_DATA,
  output logic                      oEVENT_VALID,
  output logic                      oEVENT_EXT,
  output logic                      oEVENT_BREAK,
  output logic [7:0]                oEVENT_CODE,
  input  logic                      iEVENT_READ,
  output logic [P_FIFO_DEPTH_N:0]   oEVENT_COUNT,
  output logic                      oOVERFLOW,
  output logic                      oPROTO_ERR,
  input  logic                      iCLEAR_FLAGS
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  localparam logic [P_TIMEOUT_W-1:0]    TMO_LAST = P_TIMEOUT_W'(P_TIMEOUT - 1);
  localparam logic [P_FIFO_DEPTH_N:0]   CNT_FULL = (P_FIFO_DEPTH_N + 1)'(P_FIFO_DEPTH);
  localparam logic [P_FIFO_DEPTH_N:0]   CNT_ONE  = (P_FIFO_DEPTH_N + 1)'(1);

  state_t                    state_reg;
  logic [2:0]                skip_reg;
  logic [P_TIMEOUT_W-1:0]    tmo_reg;

  logic [9:0]                mem [P_FIFO_DEPTH];
  logic [P_FIFO_DEPTH_N-1:0] wr_ptr_reg;
  logic [P_FIFO_DEPTH_N-1:0] rd_ptr_reg;
  logic [P_FIFO_DEPTH_N:0]   count_reg;
  logic                      overflow_reg;
  logic                      proto_err_reg;

  // Byte classification
  logic is_e0, is_f0, is_e1, is_bad, is_prefix;
  assign is_e0     = (iPS2_DATA == 8'hE0);
  assign is_f0     = (iPS2_DATA == 8'hF0);
  assign is_e1     = (iPS2_DATA == 8'hE1);
  assign is_bad    = (iPS2_DATA == 8'h00) || (iPS2_DATA == 8'hFF);
  assign is_prefix = is_e0 || is_f0 || is_e1;

  // Sequence outcome for this cycle: event to push, its fields, and protocol errors
  logic       timeout_hit;
  logic       ev_push;
  logic       ev_ext;
  logic       ev_brk;
  logic [7:0] ev_code;
  logic       ev_err;

  assign timeout_hit = !iPS2_REQ && (state_reg != S_IDLE) && (tmo_reg == TMO_LAST);
  assign ev_push = iPS2_REQ &&
                   (((state_reg == S_PAUSE) && (skip_reg == 3'd1)) ||
                    ((state_reg != S_PAUSE) && !is_prefix && !is_bad));
  assign ev_ext  = (state_reg == S_EXT) || (state_reg == S_EXT_BRK) || (state_reg == S_PAUSE);
  assign ev_brk  = (state_reg == S_BRK) || (state_reg == S_EXT_BRK);
  assign ev_code = (state_reg == S_PAUSE) ? 8'hE1 : iPS2_DATA;
  // Pause bytes are never inspected; only F0 after E0 is a legal second prefix.
  assign ev_err  = timeout_hit ||
                   (iPS2_REQ && (state_reg != S_PAUSE) &&
                    (is_bad || (is_prefix && (state_reg != S_IDLE) &&
                                !((state_reg == S_EXT) && is_f0))));

  // FIFO handshake
  logic pop, full, push_ok, ovf_set;
  assign pop     = iEVENT_READ && (count_reg != '0);
  assign full    = (count_reg == CNT_FULL);
  assign push_ok = ev_push && (!full || pop);
  assign ovf_set = ev_push && full && !pop;

  // Prefix-sequence FSM with pause byte skip counter and inter-byte timeout
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_reg <= S_IDLE;
      skip_reg  <= 3'd0;
      tmo_reg   <= '0;
    end else begin
      tmo_reg <= (iPS2_REQ || (state_reg == S_IDLE)) ? '0 : tmo_reg + P_TIMEOUT_W'(1);
      if (iPS2_REQ) begin
        case (state_reg)
          S_IDLE: begin
            if (is_e0) begin
              state_reg <= S_EXT;
            end else if (is_f0) begin
              state_reg <= S_BRK;
            end else if (is_e1) begin
              state_reg <= S_PAUSE;
              skip_reg  <= 3'd7;
            end
          end
          S_EXT:     state_reg <= is_f0 ? S_EXT_BRK : S_IDLE;
          S_BRK:     state_reg <= S_IDLE;
          S_EXT_BRK: state_reg <= S_IDLE;
          S_PAUSE: begin
            skip_reg <= skip_reg - 3'd1;
            if (skip_reg == 3'd1) state_reg <= S_IDLE;
          end
          default:   state_reg <= S_IDLE;
        endcase
      end else if (timeout_hit) begin
        state_reg <= S_IDLE;
      end
    end
  end

  // Event storage; contents need no reset because the head is gated by the count
  always_ff @(posedge iCLOCK) begin
    if (push_ok) mem[wr_ptr_reg] <= {ev_ext, ev_brk, ev_code};
  end

  // FIFO pointers, occupancy and sticky flags (a same-cycle set beats a clear)
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
      if (ovf_set)           overflow_reg <= 1'b1;
      else if (iCLEAR_FLAGS) overflow_reg <= 1'b0;
      if (ev_err)            proto_err_reg <= 1'b1;
      else if (iCLEAR_FLAGS) proto_err_reg <= 1'b0;
    end
  end

  logic [9:0] head;
  assign head         = mem[rd_ptr_reg];
  assign oEVENT_VALID = (count_reg != '0);
  assign oEVENT_EXT   = oEVENT_VALID & head[9];
  assign oEVENT_BREAK = oEVENT_VALID & head[8];
  assign oEVENT_CODE  = oEVENT_VALID ? head[7:0] : 8'h00;
  assign oEVENT_COUNT = count_reg;
  assign oOVERFLOW    = overflow_reg;
  assign oPROTO_ERR   = proto_err_reg;

endmodule

// File: tb/tb_gci_std_kmc_ps2_scancode_decoder.sv
// Bench for the PS/2 scancode decoder: sequence-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_gci_std_kmc_ps2_scancode_decoder;

  localparam int DEPTH   = 16;
  localparam int DEPTH_N = 4;
  localparam int TMO     = 20;
  localparam int TMO_W   = 5;

  logic               clk = 1'b0;
  logic               srst = 1'b1;
  logic               req = 1'b0;
  logic [7:0]         data = 8'h00;
  logic               rd = 1'b0;
  logic               clr = 1'b0;
  logic               ev_valid, ev_ext, ev_brk, ovf, perr;
  logic [7:0]         ev_code;
  logic [DEPTH_N:0]   ev_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gci_std_kmc_ps2_scancode_decoder #(
    .P_FIFO_DEPTH(DEPTH), .P_FIFO_DEPTH_N(DEPTH_N),
    .P_TIMEOUT(TMO), .P_TIMEOUT_W(TMO_W)
  ) dut (
    .iCLOCK(clk), .iRESET_SYNC(srst), .iPS2_REQ(req), .iPS2_DATA(data),
    .oEVENT_VALID(ev_valid), .oEVENT_EXT(ev_ext), .oEVENT_BREAK(ev_brk),
    .oEVENT_CODE(ev_code), .iEVENT_READ(rd), .oEVENT_COUNT(ev_count),
    .oOVERFLOW(ovf), .oPROTO_ERR(perr), .iCLEAR_FLAGS(clr)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte sequences, queue FIFO) ----------------
  logic [7:0] seq[$];
  logic [9:0] mq[$];
  int         idle_n = 0;
  logic       m_ovf = 1'b0, m_err = 1'b0, started = 1'b0;
  logic       s_rst, s_req, s_rd, s_clr;
  logic [7:0] s_d;
  logic       ev, set_err, set_ovf, m_pop, bext, bbrk;
  logic [9:0] word, exp_head;

  always @(posedge clk) begin
    s_rst = srst; s_req = req; s_d = data; s_rd = rd; s_clr = clr;
    if (s_rst) begin
      started = 1'b1;
      seq.delete(); mq.delete();
      idle_n = 0; m_ovf = 1'b0; m_err = 1'b0;
    end else begin
      ev = 1'b0; set_err = 1'b0; set_ovf = 1'b0; word = '0;
      if (s_req) begin
        idle_n = 0;
        seq.push_back(s_d);
        if (seq.size() > 1 && seq[0] == 8'hE1) begin
          if (seq.size() == 8) begin
            ev = 1'b1; word = {1'b1, 1'b0, 8'hE1}; seq.delete();
          end
        end else if (s_d == 8'h00 || s_d == 8'hFF) begin
          set_err = 1'b1; seq.delete();
        end else if (s_d == 8'hE0 || s_d == 8'hF0 || s_d == 8'hE1) begin
          if (!(seq.size() == 1 || (seq.size() == 2 && seq[0] == 8'hE0 && seq[1] == 8'hF0))) begin
            set_err = 1'b1; seq.delete();
          end
        end else begin
          bext = 1'b0; bbrk = 1'b0;
          for (int i = 0; i < seq.size() - 1; i++) begin
            if (seq[i] == 8'hE0) bext = 1'b1;
            if (seq[i] == 8'hF0) bbrk = 1'b1;
          end
          ev = 1'b1; word = {bext, bbrk, s_d}; seq.delete();
        end
      end else if (seq.size() != 0) begin
        idle_n++;
        if (idle_n == TMO) begin
          set_err = 1'b1; seq.delete(); idle_n = 0;
        end
      end else begin
        idle_n = 0;
      end
      m_pop = s_rd && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (ev) begin
        if (mq.size() < DEPTH) mq.push_back(word);
        else set_ovf = 1'b1;
      end
      if (set_ovf) m_ovf = 1'b1; else if (s_clr) m_ovf = 1'b0;
      if (set_err) m_err = 1'b1; else if (s_clr) m_err = 1'b0;
    end
    #1;
    if (started) begin
      exp_head = (mq.size() > 0) ? mq[0] : 10'h000;
      chk("model_valid", ev_valid, mq.size() > 0);
      chk("model_count", ev_count, mq.size());
      chk("model_head", {ev_ext, ev_brk, ev_code}, exp_head);
      chk("model_ovf", ovf, m_ovf);
      chk("model_perr", perr, m_err);
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle of inputs at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic rs, input logic r, input logic [7:0] d,
                     input logic rdi, input logic cl);
    srst = rs; req = r; data = d; rd = rdi; clr = cl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 0);
  endtask

  task automatic drain;
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 0, 1);
  endtask

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] multi_seq [5] = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75};
  int         r;
  logic [7:0] b;

  initial begin
    @(negedge clk);
    cyc(1, 0, 8'h00, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    chk("reset_valid", ev_valid, 0);
    chk("reset_count", ev_count, 0);
    chk("reset_flags", {ovf, perr}, 0);
    chk("reset_head", {ev_ext, ev_brk, ev_code}, 0);
    cyc(0, 0, 8'h00, 0, 0);

    // single make code
    cyc(0, 1, 8'h1C, 0, 0);
    chk("make_valid", ev_valid, 1);
    chk("make_head", {ev_ext, ev_brk, ev_code}, 10'h01C);
    cyc(0, 0, 8'h00, 1, 0);
    chk("make_popped", ev_count, 0);
    cyc(0, 0, 8'h00, 1, 0); // pop on empty

    // break then extended break, back to back
    foreach (multi_seq[i]) cyc(0, 1, multi_seq[i], 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("multi_count", ev_count, 2);
    chk("multi_head0", {ev_ext, ev_brk, ev_code}, 10'h11C);
    cyc(0, 0, 8'h00, 1, 0);
    chk("multi_head1", {ev_ext, ev_brk, ev_code}, 10'h375);
    cyc(0, 0, 8'h00, 1, 0);

    // pause sequence
    foreach (pause_seq[i]) cyc(0, 1, pause_seq[i], 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("pause_count", ev_count, 1);
    chk("pause_head", {ev_ext, ev_brk, ev_code}, 10'h2E1);
    chk("pause_noerr", perr, 0);
    cyc(0, 0, 8'h00, 1, 0);

    // timeout inside an E0 sequence
    cyc(0, 1, 8'hE0, 0, 0);
    idle(TMO);
    cyc(0, 1, 8'h1C, 0, 0);
    chk("tmo_err", perr, 1);
    chk("tmo_count", ev_count, 1);
    chk("tmo_head", {ev_ext, ev_brk, ev_code}, 10'h01C);
    cyc(0, 0, 8'h00, 1, 1);
    chk("clear_err", perr, 0);

    // overflow: 17 pushes into 16 entries
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 1, 8'(i + 1), 0, 0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("ovf_count", ev_count, DEPTH);
    chk("ovf_flag", ovf, 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_order", ev_code, i + 1);
      cyc(0, 0, 8'h00, 1, 0);
    end
    chk("ovf_empty", ev_valid, 0);
    cyc(0, 0, 8'h00, 0, 1);

    // full FIFO with push and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'(8'h30 + i), 0, 0);
    cyc(0, 1, 8'h55, 1, 0);
    chk("fullrw_count", ev_count, DEPTH);
    chk("fullrw_ovf", ovf, 0);
    chk("fullrw_head", ev_code, 8'h31);
    for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 8'h00, 1, 0);
    chk("fullrw_tail", ev_code, 8'h55);
    cyc(0, 0, 8'h00, 1, 0);

    // reset mid-sequence with data queued
    cyc(0, 1, 8'h1C, 0, 0);
    cyc(0, 1, 8'hE0, 0, 0);
    cyc(1, 0, 8'h00, 0, 0);
    chk("midrst_count", ev_count, 0);
    cyc(0, 1, 8'h2A, 0, 0);
    chk("midrst_head", {ev_ext, ev_brk, ev_code}, 10'h02A);
    drain();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        idle(TMO + 3);
      end else begin
        r = $urandom_range(0, 19);
        case (r)
          0, 1, 2: b = 8'hE0;
          3, 4, 5: b = 8'hF0;
          6:       b = 8'hE1;
          7:       b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
          default: b = 8'($urandom_range(1, 254));
        endcase
        cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) != 0), b,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
